seg_chaser_gen: RTL and testbench
=================================

Name: seg_chaser_gen

Overview:
Parametrised seven-segment chase animator for a TinyTapeout user slot. It drives an 8-bit segment bus (a..g plus dp) from a programmable prescaler. It supports four animation patterns, forward/reverse direction, hold, and a dimmed PWM "trail" on the previously lit segment. It sits between the slot's io_in switches and io_out segment pins.

Parameters:
COUNTER_WIDTH, 24, prescaler counter width in bits; must be greater than SPEED_BITS.
SPEED_BITS, 3, width of the speed select input.
TRAIL_EN, 1, 1 shows the previous step's segments at 1/4 duty; 0 disables the trail.
ACTIVE_LOW, 1, 1 inverts all eight outputs (common-anode display).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
speed  in  SPEED_BITS  step rate select; larger value gives a faster step
dir  in  1  1 = forward, 0 = reverse
mode  in  2  pattern select (0 fig8, 1 circle, 2 vbounce, 3 blink)
hold  in  1  freezes the step pointer
seg_out  out  8  bit0 = a … bit6 = g, bit7 = dp; polarity set by ACTIVE_LOW
step_o  out  1  one-cycle pulse after each pointer advance

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Reset values:
  - cnt = 0, ptr = 0, pwm = 0, tail_mask = 0, step_o = 0.
  - seg_out = all off: 8'hFF when ACTIVE_LOW = 1, 8'h00 otherwise.
  - speed_q, mode_q and hold_q are reset to 0.
- Input registration: speed, mode and hold are registered into speed_q, mode_q and hold_q every cycle. dir is used directly.
- Prescaler:
  - limit = {~speed_q, (COUNTER_WIDTH-SPEED_BITS) ones}.
  - Each cycle: if cnt >= limit, then tick = 1 and cnt <= 0; otherwise cnt <= cnt + 1.
  - The prescaler runs while hold is asserted. A speed change takes effect at the next compare; the >= compare handles a limit that falls below cnt.
- Pattern tables (segment indices), length L:
  - mode 0 (fig8): a,b,g,e,d,c,g,f; L = 8.
  - mode 1 (circle): a,b,c,d,e,f; L = 6.
  - mode 2 (vbounce): a,g,d,g; L = 4.
  - mode 3 (blink): step0 = all a..g, step1 = none; L = 2.
- Pointer advance on tick && !hold_q:
  - dir = 1: ptr <= (ptr == L-1) ? 0 : ptr+1.
  - dir = 0: ptr <= (ptr == 0) ? L-1 : ptr-1.
  - tail_mask <= current head mask.
  - step_o <= 1 (high for exactly the cycle after the advancing edge); otherwise step_o <= 0.
- Mode change: when mode differs from mode_q, the next edge forces ptr <= 0 and tail_mask <= 0, and no step_o is issued. This has priority over a coincident tick.
- Trail PWM: pwm is a free-running 2-bit counter; trail_on = (pwm == 0).
- Output composition:
  - head = table[mode_q][ptr].
  - lit[6:0] = head | (TRAIL_EN && mode_q != 3 && trail_on ? tail_mask : 0). Where head and tail share a segment, it stays fully on.
  - lit[7] (dp) = hold_q.
- Output register: seg_out <= ACTIVE_LOW ? ~lit : lit. seg_out updates one cycle after ptr changes, so a new pattern appears the cycle after step_o rises.
- Reset mid-operation: all state returns to reset values on the next edge, and no step_o is emitted. The first tick after release occurs after limit+1 cycles.

Decomposition:
- Package seg_chaser_pkg:
  - segment bit index constants SEG_A..SEG_G and SEG_DP;
  - mode encodings;
  - pattern tables as 7-bit mask arrays;
  - pattern_len(mode) function;
  - 3-bit ptr type.
- Sub-module seg_prescaler (COUNTER_WIDTH, SPEED_BITS): speed_q and reset in, tick out.

Test Plan:
All scenarios use COUNTER_WIDTH=6, SPEED_BITS=3, ACTIVE_LOW=1.
1. Speed 7, mode 0, dir 1, TRAIL_EN 0, reset then release → step_o every 8 cycles. seg_out (active-low) sequence: FE, FD, BF, EF, F7, FB, BF, DF, then repeats FE.
2. Speed 0 → step_o period 64 cycles. Switch speed 0→7 while cnt = 40 → tick on the next cycle (cnt >= 7), then period 8.
3. Mode 1, dir 0 from ptr 0 → next head is f (seg_out DF), then e (EF). Hold = 1 → dp low (bit7 = 0), no step_o, pattern frozen; release resumes.
4. Mode change 0→2 coincident with a tick → ptr = 0 (head a, FE), no step_o that cycle, tail cleared.
5. TRAIL_EN 1, mode 0, after step a→b → bit1 low every cycle; bit0 low only when pwm == 0 (1 of 4 cycles). Mode 3 shows no trail; it blinks 80 / FF at full duty.
6. Assert reset mid-animation → next cycle seg_out = FF, step_o = 0. After release, the first step_o arrives exactly limit+1 cycles later.

Source files
------------

// File: rtl/seg_chaser_pkg.sv
// Shared definitions for the seven-segment chase animator: segment indices,
// mode encodings, pattern tables and pattern helpers.
package seg_chaser_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic [1:0] {
        MODE_FIG8    = 2'd0,
        MODE_CIRCLE  = 2'd1,
        MODE_VBOUNCE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef logic [2:0] ptr_t;
    typedef logic [6:0] seg_mask_t;

    localparam seg_mask_t M_A = seg_mask_t'(1) << SEG_A;
    localparam seg_mask_t M_B = seg_mask_t'(1) << SEG_B;
    localparam seg_mask_t M_C = seg_mask_t'(1) << SEG_C;
    localparam seg_mask_t M_D = seg_mask_t'(1) << SEG_D;
    localparam seg_mask_t M_E = seg_mask_t'(1) << SEG_E;
    localparam seg_mask_t M_F = seg_mask_t'(1) << SEG_F;
    localparam seg_mask_t M_G = seg_mask_t'(1) << SEG_G;

    localparam seg_mask_t FIG8_TBL    [8] = '{M_A, M_B, M_G, M_E, M_D, M_C, M_G, M_F};
    localparam seg_mask_t CIRCLE_TBL  [6] = '{M_A, M_B, M_C, M_D, M_E, M_F};
    localparam seg_mask_t VBOUNCE_TBL [4] = '{M_A, M_G, M_D, M_G};
    localparam seg_mask_t BLINK_TBL   [2] = '{7'h7F, 7'h00};

    function automatic logic [3:0] pattern_len(input mode_e m);
        logic [3:0] len;
        case (m)
            MODE_FIG8:    len = 4'd8;
            MODE_CIRCLE:  len = 4'd6;
            MODE_VBOUNCE: len = 4'd4;
            MODE_BLINK:   len = 4'd2;
            default:      len = 4'd2;
        endcase
        return len;
    endfunction

    // Last valid pointer value; the wrap point for forward stepping.
    function automatic ptr_t pattern_last(input mode_e m);
        logic [3:0] last;
        last = pattern_len(m) - 4'd1;
        return last[2:0];
    endfunction

    function automatic seg_mask_t pattern_head(input mode_e m, input ptr_t p);
        seg_mask_t head;
        case (m)
            MODE_FIG8:    head = FIG8_TBL[p];
            MODE_CIRCLE:  head = (p < 3'd6) ? CIRCLE_TBL[p] : '0;
            MODE_VBOUNCE: head = VBOUNCE_TBL[p[1:0]];
            MODE_BLINK:   head = BLINK_TBL[p[0]];
            default:      head = '0;
        endcase
        return head;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Step-rate prescaler: counts up to a speed-derived limit and pulses tick.
module seg_prescaler #(
    parameter int COUNTER_WIDTH = 24,
    parameter int SPEED_BITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPEED_BITS-1:0] speed_q,
    output logic                  tick
);

    localparam int LOW_BITS = COUNTER_WIDTH - SPEED_BITS;

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [COUNTER_WIDTH-1:0] limit;

    // Inverting speed makes larger speed values give a shorter period; the
    // >= compare copes with a limit that drops below the current count.
    always_comb begin
        limit = {~speed_q, {LOW_BITS{1'b1}}};
        tick  = (cnt_q >= limit);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_chaser_gen.sv
// Seven-segment chase animator: pattern pointer, dimmed trail and registered
// segment outputs driven from the step prescaler.
module seg_chaser_gen
    import seg_chaser_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24,
    parameter int SPEED_BITS    = 3,
    parameter bit TRAIL_EN      = 1'b1,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SPEED_BITS-1:0] speed,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  hold,
    output logic [7:0]            seg_out,
    output logic                  step_o
);

    localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [SPEED_BITS-1:0] speed_q, speed_d;
    mode_e                 mode_q, mode_d;
    logic                  hold_q, hold_d;
    ptr_t                  ptr_q, ptr_d;
    seg_mask_t             tail_q, tail_d;
    logic [1:0]            pwm_q, pwm_d;
    logic                  step_q, step_d;
    logic [7:0]            seg_q, seg_d;

    logic                  tick;
    seg_mask_t             head;
    logic                  trail_on;
    logic [7:0]            lit;

    seg_prescaler #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .SPEED_BITS   (SPEED_BITS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .speed_q(speed_q),
        .tick   (tick)
    );

    always_comb begin
        speed_d  = speed;
        mode_d   = mode_e'(mode);
        hold_d   = hold;
        pwm_d    = pwm_q + 2'd1;
        ptr_d    = ptr_q;
        tail_d   = tail_q;
        step_d   = 1'b0;

        head     = pattern_head(mode_q, ptr_q);
        trail_on = (pwm_q == 2'd0);

        lit      = '0;
        lit[6:0] = head;
        if (TRAIL_EN && (mode_q != MODE_BLINK) && trail_on) begin
            lit[6:0] = head | tail_q;
        end
        lit[SEG_DP] = hold_q;
        seg_d    = ACTIVE_LOW ? ~lit : lit;

        // A mode switch restarts the new pattern and outranks a coincident tick.
        if (mode_d != mode_q) begin
            ptr_d  = '0;
            tail_d = '0;
        end else if (tick && !hold_q) begin
            step_d = 1'b1;
            tail_d = head;
            if (dir) begin
                ptr_d = (ptr_q == pattern_last(mode_q)) ? ptr_t'(0) : ptr_q + 3'd1;
            end else begin
                ptr_d = (ptr_q == 3'd0) ? pattern_last(mode_q) : ptr_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q <= '0;
            mode_q  <= MODE_FIG8;
            hold_q  <= 1'b0;
            ptr_q   <= '0;
            tail_q  <= '0;
            pwm_q   <= '0;
            step_q  <= 1'b0;
            seg_q   <= SEG_OFF;
        end else begin
            speed_q <= speed_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            tail_q  <= tail_d;
            pwm_q   <= pwm_d;
            step_q  <= step_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out = seg_q;
    assign step_o  = step_q;

endmodule

// File: tb/tb_seg_chaser_gen.sv
// Bench for seg_chaser_gen: two instances (trail off / on) sharing stimulus,
// checked every cycle against a reference model plus directed scenario checks.
module tb_seg_chaser_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] speed;
    logic       dir;
    logic [1:0] mode;
    logic       hold;
    logic [7:0] seg_plain, seg_trail;
    logic       step_plain, step_trail;

    always #5 clk = ~clk;

    seg_chaser_gen #(
        .COUNTER_WIDTH(6), .SPEED_BITS(3), .TRAIL_EN(1'b0), .ACTIVE_LOW(1'b1)
    ) dut_plain (
        .clk(clk), .reset(reset), .speed(speed), .dir(dir), .mode(mode),
        .hold(hold), .seg_out(seg_plain), .step_o(step_plain)
    );

    seg_chaser_gen #(
        .COUNTER_WIDTH(6), .SPEED_BITS(3), .TRAIL_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut_trail (
        .clk(clk), .reset(reset), .speed(speed), .dir(dir), .mode(mode),
        .hold(hold), .seg_out(seg_trail), .step_o(step_trail)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model, expressed as segment-index sequences
    int fig8_seq   [8] = '{0, 1, 6, 4, 3, 2, 6, 5};
    int circle_seq [6] = '{0, 1, 2, 3, 4, 5};
    int vb_seq     [4] = '{0, 6, 3, 6};

    int         m_cnt, m_ptr, m_pwm, m_speed_q, m_mode_q;
    bit         m_hold_q;
    logic [6:0] m_tail;
    logic [7:0] m_seg0, m_seg1;
    bit         m_step;

    function automatic logic [6:0] ref_head(input int md, input int p);
        logic [6:0] one = 7'd1;
        case (md)
            0: return one << fig8_seq[p];
            1: return one << circle_seq[p];
            2: return one << vb_seq[p];
            default: return (p == 0) ? 7'h7F : 7'h00;
        endcase
    endfunction

    function automatic int ref_len(input int md);
        case (md)
            0: return 8;
            1: return 6;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    task automatic model_step();
        logic [6:0] hd;
        int limit, len;
        bit tk;
        if (reset) begin
            m_cnt = 0; m_ptr = 0; m_pwm = 0; m_speed_q = 0; m_mode_q = 0;
            m_hold_q = 0; m_tail = '0; m_seg0 = 8'hFF; m_seg1 = 8'hFF; m_step = 0;
        end else begin
            hd     = ref_head(m_mode_q, m_ptr);
            m_seg0 = ~{m_hold_q, hd};
            m_seg1 = ~{m_hold_q, hd | ((m_mode_q != 3 && m_pwm == 0) ? m_tail : 7'h00)};
            limit  = ((7 - m_speed_q) * 8) + 7;
            tk     = (m_cnt >= limit);
            len    = ref_len(m_mode_q);
            m_step = 0;
            if (int'(mode) != m_mode_q) begin
                m_ptr = 0; m_tail = '0;
            end else if (tk && !m_hold_q) begin
                m_ptr  = dir ? (m_ptr + 1) % len : (m_ptr + len - 1) % len;
                m_tail = hd;
                m_step = 1;
            end
            m_cnt     = tk ? 0 : m_cnt + 1;
            m_pwm     = (m_pwm + 1) % 4;
            m_speed_q = int'(speed);
            m_mode_q  = int'(mode);
            m_hold_q  = hold;
        end
    endtask

    // One clock: predict, push, advance, pop and compare both instances.
    task automatic cycle();
        logic [16:0] e;
        model_step();
        exp_q.push_back({m_seg0, m_seg1, m_step});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("seg_plain", seg_plain, e[16:9]);
        check_eq("seg_trail", seg_trail, e[8:1]);
        check_eq("step_plain", step_plain, e[0]);
        check_eq("step_trail", step_trail, e[0]);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_step(input int max_cyc, output int n);
        bit done = 0;
        n = 0;
        while (!done) begin
            cycle();
            n++;
            if (step_plain === 1'b1) done = 1;
            else if (n >= max_cyc) begin
                check_eq("step_timeout", step_plain, 1);
                done = 1;
            end
        end
    endtask

    logic [7:0] s1_seq [9] = '{8'hFD, 8'hBF, 8'hEF, 8'hF7, 8'hFB, 8'hBF, 8'hDF, 8'hFE, 8'hFD};

    initial begin
        int n, cnt_a, cnt_b, cnt_c, cnt_d;
        reset = 1'b1; speed = 3'd7; dir = 1'b1; mode = 2'd0; hold = 1'b0;
        run(3);
        check_eq("reset_seg", seg_plain, 8'hFF);
        check_eq("reset_step", step_plain, 0);
        reset = 1'b0;

        // Fig-8 forward at speed 7: period 8, known segment sequence
        wait_step(20, n);
        check_eq("s1_first_step", n, 8);
        cycle();
        check_eq("s1_seg", seg_plain, s1_seq[0]);
        for (int k = 1; k < 9; k++) begin
            wait_step(20, n);
            check_eq("s1_gap", n, 7);
            cycle();
            check_eq("s1_seg", seg_plain, s1_seq[k]);
        end

        // Slowest speed, then a speed-up while the counter is well past the new limit
        speed = 3'd0;
        wait_step(80, n);
        wait_step(80, n);
        check_eq("s2_period64", n, 64);
        run(40);
        speed = 3'd7;
        wait_step(5, n);
        check_eq("s2_fast_tick", n, 2);
        wait_step(20, n);
        check_eq("s2_period8", n, 8);

        // Circle reverse, then hold
        mode = 2'd1; dir = 1'b0;
        cycle();
        wait_step(20, n); cycle();
        check_eq("s3_head_f", seg_plain, 8'hDF);
        wait_step(20, n); cycle();
        check_eq("s3_head_e", seg_plain, 8'hEF);
        hold = 1'b1;
        run(2);
        check_eq("s3_hold_dp", seg_plain, 8'h6F);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (step_plain) cnt_a++;
        end
        check_eq("s3_hold_nostep", cnt_a, 0);
        check_eq("s3_hold_frozen", seg_plain, 8'h6F);
        hold = 1'b0;
        wait_step(20, n); cycle();
        check_eq("s3_resume_d", seg_plain, 8'hF7);

        // Mode change landing on a tick edge
        dir = 1'b1; mode = 2'd0;
        cycle();
        wait_step(20, n);
        run(7);
        mode = 2'd2;
        cycle();
        check_eq("s4_no_step", step_plain, 0);
        cycle();
        check_eq("s4_head_a", seg_plain, 8'hFE);
        check_eq("s4_tail_clear", seg_trail, 8'hFE);
        wait_step(20, n);
        check_eq("s4_gap", n, 7);
        cycle();
        check_eq("s4_head_g", seg_plain, 8'hBF);

        // Trail at quarter duty in fig-8, none in blink
        mode = 2'd0;
        cycle();
        wait_step(20, n);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!seg_trail[1]) cnt_a++;
            if (!seg_trail[0]) cnt_b++;
            if (!seg_plain[0]) cnt_c++;
        end
        check_eq("s5_head_full", cnt_a, 8);
        check_eq("s5_trail_quarter", cnt_b, 2);
        check_eq("s5_plain_no_trail", cnt_c, 0);
        mode = 2'd3;
        cycle();
        cnt_a = 0; cnt_d = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (seg_trail == 8'h80) cnt_a++;
            else if (seg_trail != 8'hFF) cnt_d++;
        end
        check_eq("s5_blink_on", cnt_a, 8);
        check_eq("s5_blink_clean", cnt_d, 0);

        // Reset on a tick edge mid-animation
        mode = 2'd0;
        cycle();
        wait_step(20, n);
        run(7);
        reset = 1'b1;
        cycle();
        check_eq("s6_reset_seg", seg_plain, 8'hFF);
        check_eq("s6_reset_seg_trail", seg_trail, 8'hFF);
        check_eq("s6_reset_step", step_plain, 0);
        cycle();
        reset = 1'b0;
        wait_step(20, n);
        check_eq("s6_first_step", n, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
